// File: rtl/tbox_auto_player.sv
// Automatic TBox opponent: snapshots the board on start, picks win > block > centre > corner > edge, issues one set.
// Latency start->set: win on line i = i+2, block on line i = i+10, preference = 18; done follows board confirmation or timeout.
// No backpressure: start is taken only in IDLE; WAIT gives up after TIMEOUT cycles without confirmation.
module tbox_auto_player #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       my_symbol,
    input  logic [8:0] valid_in,
    input  logic [8:0] symbol_in,
    input  logic [1:0] game_state,
    output logic       set,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       busy,
    output logic       done,
    output logic       no_move,
    output logic       err
);

    localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN_WIN = 3'd1,
        SCAN_BLK = 3'd2,
        PREF     = 3'd3,
        ISSUE    = 3'd4,
        WAIT     = 3'd5,
        FIN      = 3'd6
    } state_t;

    state_t           state, next_state;
    logic [8:0]       snap_vld;
    logic [8:0]       snap_sym;
    logic             snap_me;
    logic [2:0]       line_ctr;
    logic [3:0]       target;
    logic [WCW-1:0]   wait_ctr;
    logic             no_move_q;
    logic             err_q;

    logic             scan_hit;
    logic [3:0]       scan_cell;
    logic [3:0]       pref_cell;
    logic             game_over;
    logic             timeout_hit;

    // Three cell indices of each line, packed {a,b,c}.
    function automatic logic [11:0] line_cells(input logic [2:0] l);
        case (l)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            default: line_cells = {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    function automatic logic [3:0] pref_at(input logic [3:0] i);
        case (i)
            4'd0:    pref_at = 4'd4;
            4'd1:    pref_at = 4'd0;
            4'd2:    pref_at = 4'd2;
            4'd3:    pref_at = 4'd6;
            4'd4:    pref_at = 4'd8;
            4'd5:    pref_at = 4'd1;
            4'd6:    pref_at = 4'd3;
            4'd7:    pref_at = 4'd5;
            default: pref_at = 4'd7;
        endcase
    endfunction

    // {row,col} in 1-based board coordinates for a cell index.
    function automatic logic [3:0] cell_rc(input logic [3:0] c);
        case (c)
            4'd0:    cell_rc = 4'b01_01;
            4'd1:    cell_rc = 4'b01_10;
            4'd2:    cell_rc = 4'b01_11;
            4'd3:    cell_rc = 4'b10_01;
            4'd4:    cell_rc = 4'b10_10;
            4'd5:    cell_rc = 4'b10_11;
            4'd6:    cell_rc = 4'b11_01;
            4'd7:    cell_rc = 4'b11_10;
            default: cell_rc = 4'b11_11;
        endcase
    endfunction

    assign game_over   = (game_state != 2'b00) || (valid_in == 9'h1FF);
    assign timeout_hit = (wait_ctr == WCW'(TIMEOUT - 1));

    // Line test on the snapshot: two cells of the scanned symbol and one empty cell.
    always_comb begin
        logic [11:0] cells;
        logic [3:0]  c;
        logic [1:0]  n_own;
        logic [1:0]  n_empty;
        logic        scan_sym;
        cells     = line_cells(line_ctr);
        scan_sym  = (state == SCAN_WIN) ? snap_me : ~snap_me;
        n_own     = 2'd0;
        n_empty   = 2'd0;
        scan_cell = 4'd0;
        for (int k = 0; k < 3; k++) begin
            c = cells[k*4 +: 4];
            if (!snap_vld[c]) begin
                n_empty   = n_empty + 2'd1;
                scan_cell = c;
            end else if (snap_sym[c] == scan_sym) begin
                n_own = n_own + 2'd1;
            end
        end
        scan_hit = (n_own == 2'd2) && (n_empty == 2'd1);
    end

    // Walk the preference list backwards so the earliest empty cell wins.
    always_comb begin
        logic [3:0] c;
        pref_cell = 4'd4;
        for (int i = 8; i >= 0; i--) begin
            c = pref_at(4'(i));
            if (!snap_vld[c]) pref_cell = c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = game_over ? FIN : SCAN_WIN;
            end
            SCAN_WIN: begin
                if (scan_hit)               next_state = ISSUE;
                else if (line_ctr == 3'd7)  next_state = SCAN_BLK;
            end
            SCAN_BLK: begin
                if (scan_hit)               next_state = ISSUE;
                else if (line_ctr == 3'd7)  next_state = PREF;
            end
            PREF:  next_state = ISSUE;
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (valid_in[target] || timeout_hit) next_state = FIN;
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_vld  <= '0;
            snap_sym  <= '0;
            snap_me   <= 1'b0;
            line_ctr  <= '0;
            target    <= '0;
            wait_ctr  <= '0;
            no_move_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_vld  <= valid_in;
                        snap_sym  <= symbol_in;
                        snap_me   <= my_symbol;
                        line_ctr  <= '0;
                        no_move_q <= game_over;
                        err_q     <= 1'b0;
                    end
                end
                SCAN_WIN, SCAN_BLK: begin
                    // Counter wraps 7->0, which restarts the block scan at line 0.
                    if (scan_hit) target <= scan_cell;
                    else          line_ctr <= line_ctr + 3'd1;
                end
                PREF:  target   <= pref_cell;
                ISSUE: wait_ctr <= '0;
                WAIT: begin
                    if (valid_in[target])  err_q    <= (symbol_in[target] != snap_me);
                    else if (timeout_hit)  err_q    <= 1'b1;
                    else                   wait_ctr <= wait_ctr + WCW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        logic [3:0] rc;
        rc      = cell_rc(target);
        set     = (state == ISSUE);
        row     = 2'b00;
        col     = 2'b00;
        if (state == ISSUE || state == WAIT) begin
            row = rc[3:2];
            col = rc[1:0];
        end
        busy    = (state != IDLE) && (state != FIN);
        done    = (state == FIN);
        no_move = (state == FIN) && no_move_q;
        err     = (state == FIN) && err_q;
    end

endmodule

// File: tb/tb_tbox_auto_player.sv
// Directed bench for tbox_auto_player; the bench plays TBox by updating the board after each set.
module tb_tbox_auto_player;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       my_symbol;
    logic [8:0] valid_in;
    logic [8:0] symbol_in;
    logic [1:0] game_state;
    logic       set;
    logic [1:0] row;
    logic [1:0] col;
    logic       busy;
    logic       done;
    logic       no_move;
    logic       err;

    int vectors;
    int miscompares;

    tbox_auto_player #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .my_symbol(my_symbol),
        .valid_in(valid_in), .symbol_in(symbol_in), .game_state(game_state),
        .set(set), .row(row), .col(col), .busy(busy), .done(done),
        .no_move(no_move), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled at the falling edge; after this task the DUT is in cycle 1.
    task automatic do_start(input logic me);
        my_symbol = me;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_set(input int cyc0, output int cyc);
        cyc = cyc0;
        while (!set && cyc < cyc0 + 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!set) cyc = -1;
    endtask

    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (!done && cyc < cyc0 + 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; my_symbol = 1'b0;
        valid_in = '0; symbol_in = '0; game_state = 2'b00;
        #3;
        vectors++;
        if ({set, row, col, busy, done, no_move, err} !== 9'b0) begin
            $display("FAIL reset_outputs got=%b want=%b", {set, row, col, busy, done, no_move, err}, 9'b0);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({set, busy, done} !== 3'b0) begin
            $display("FAIL idle_after_reset got=%b want=000", {set, busy, done});
            miscompares++;
        end
    endtask

    task automatic test_pref;
        int c, d;
        valid_in = '0; symbol_in = '0; game_state = 2'b00;
        do_start(1'b1);
        wait_set(1, c);
        vectors++;
        if (c !== 18) begin $display("FAIL pref_set_cycle got=%0d want=18", c); miscompares++; end
        vectors++;
        if ({row, col, busy} !== 5'b10_10_1) begin
            $display("FAIL pref_centre_rc got=%b want=10101", {row, col, busy}); miscompares++;
        end
        valid_in[4] = 1'b1; symbol_in[4] = 1'b1;
        @(negedge clk);
        vectors++;
        if ({set, row, col} !== 5'b0_10_10) begin
            $display("FAIL pref_hold_rc got=%b want=01010", {set, row, col}); miscompares++;
        end
        @(negedge clk);
        vectors++;
        if ({done, no_move, err, busy, row, col} !== 8'b1000_0000) begin
            $display("FAIL pref_done got=%b want=10000000", {done, no_move, err, busy, row, col}); miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin $display("FAIL pref_done_pulse got=%b want=0", done); miscompares++; end

        // Centre taken by X, playing O: first empty corner is cell 0.
        valid_in = 9'h010; symbol_in = 9'h010;
        do_start(1'b0);
        wait_set(1, c);
        vectors++;
        if (c !== 18 || {row, col} !== 4'b01_01) begin
            $display("FAIL pref_corner got=cyc%0d rc%b want=cyc18 rc0101", c, {row, col}); miscompares++;
        end
        valid_in[0] = 1'b1; symbol_in[0] = 1'b0;
        wait_done(c, d);
        vectors++;
        if (d !== 20 || err !== 1'b0) begin
            $display("FAIL pref_corner_done got=cyc%0d err%b want=cyc20 err0", d, err); miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_win;
        int c, d;
        valid_in = 9'h01B; symbol_in = 9'h003; game_state = 2'b00;
        do_start(1'b1);
        wait_set(1, c);
        vectors++;
        if (c !== 2 || {row, col} !== 4'b01_11) begin
            $display("FAIL win_line0 got=cyc%0d rc%b want=cyc2 rc0111", c, {row, col}); miscompares++;
        end
        valid_in[2] = 1'b1; symbol_in[2] = 1'b1; game_state = 2'b01;
        wait_done(c, d);
        vectors++;
        if (d !== 4 || {no_move, err} !== 2'b00) begin
            $display("FAIL win_done got=cyc%0d nm_err%b want=cyc4 00", d, {no_move, err}); miscompares++;
        end
        @(negedge clk);
        game_state = 2'b00;

        // Playing O, O at 0,4 and X at 1,2: win on line 6 -> cell 8.
        valid_in = 9'h017; symbol_in = 9'h006;
        do_start(1'b0);
        wait_set(1, c);
        vectors++;
        if (c !== 8 || {row, col} !== 4'b11_11) begin
            $display("FAIL win_line6_o got=cyc%0d rc%b want=cyc8 rc1111", c, {row, col}); miscompares++;
        end
        valid_in[8] = 1'b1; symbol_in[8] = 1'b0;
        wait_done(c, d);
        vectors++;
        if (d !== 10 || err !== 1'b0) begin
            $display("FAIL win_line6_done got=cyc%0d err%b want=cyc10 err0", d, err); miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_block;
        int c, d;
        valid_in = 9'h119; symbol_in = 9'h101; game_state = 2'b00;
        do_start(1'b1);
        wait_set(1, c);
        vectors++;
        if (c !== 11 || {row, col} !== 4'b10_11) begin
            $display("FAIL block_line1 got=cyc%0d rc%b want=cyc11 rc1011", c, {row, col}); miscompares++;
        end
        // Board reports the cell taken by O: the wrong symbol.
        valid_in[5] = 1'b1; symbol_in[5] = 1'b0;
        wait_done(c, d);
        vectors++;
        if (d !== 13 || {no_move, err} !== 2'b01) begin
            $display("FAIL block_wrong_sym got=cyc%0d nm_err%b want=cyc13 01", d, {no_move, err}); miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_no_move;
        int nset;
        for (int t = 0; t < 2; t++) begin
            game_state = (t == 0) ? 2'b01 : 2'b00;
            valid_in   = (t == 0) ? 9'h003 : 9'h1FF;
            symbol_in  = 9'h0AA;
            nset = 0;
            do_start(1'b1);
            vectors++;
            if ({done, no_move, err, set, busy} !== 5'b11000) begin
                $display("FAIL no_move_%0d got=%b want=11000", t, {done, no_move, err, set, busy}); miscompares++;
            end
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (set) nset++;
            end
            vectors++;
            if (nset !== 0 || done !== 1'b0) begin
                $display("FAIL no_move_quiet_%0d got=sets%0d done%b want=sets0 done0", t, nset, done); miscompares++;
            end
        end
        game_state = 2'b00;
    endtask

    task automatic test_timeout;
        int cyc, nset, sc, dc;
        logic e, b, prev_busy;
        valid_in = 9'h01B; symbol_in = 9'h003; game_state = 2'b00;
        cyc = 1; nset = 0; sc = -1; dc = -1; e = 1'b0; b = 1'b1; prev_busy = 1'b0;
        do_start(1'b1);
        for (int k = 0; k < 40 && dc < 0; k++) begin
            if (set) begin nset++; sc = cyc; end
            if (done) begin dc = cyc; e = err; b = busy; end
            else prev_busy = busy;
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (sc !== 2 || nset !== 1) begin
            $display("FAIL timeout_set got=cyc%0d sets%0d want=cyc2 sets1", sc, nset); miscompares++;
        end
        vectors++;
        if (dc - sc !== 17 || e !== 1'b1) begin
            $display("FAIL timeout_done got=delta%0d err%b want=delta17 err1", dc - sc, e); miscompares++;
        end
        vectors++;
        if ({prev_busy, b} !== 2'b10) begin
            $display("FAIL timeout_busy got=%b want=10", {prev_busy, b}); miscompares++;
        end
    endtask

    task automatic test_reset_mid;
        int c, d;
        valid_in = 9'h01B; symbol_in = 9'h003; game_state = 2'b00;
        do_start(1'b1);
        wait_set(1, c);
        @(negedge clk);
        vectors++;
        if ({row, col, busy} !== 5'b01_11_1) begin
            $display("FAIL wait_hold got=%b want=01111", {row, col, busy}); miscompares++;
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({set, row, col, busy, done, no_move, err} !== 9'b0) begin
            $display("FAIL reset_mid got=%b want=%b", {set, row, col, busy, done, no_move, err}, 9'b0); miscompares++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        valid_in = 9'h119; symbol_in = 9'h101;
        do_start(1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1; my_symbol = 1'b0;
        @(negedge clk);
        start = 1'b0; my_symbol = 1'b1;
        wait_set(5, c);
        vectors++;
        if (c !== 11 || {row, col} !== 4'b10_11) begin
            $display("FAIL start_while_busy got=cyc%0d rc%b want=cyc11 rc1011", c, {row, col}); miscompares++;
        end
        valid_in[5] = 1'b1; symbol_in[5] = 1'b1;
        wait_done(c, d);
        vectors++;
        if (d !== 13 || {no_move, err} !== 2'b00) begin
            $display("FAIL after_reset_done got=cyc%0d nm_err%b want=cyc13 00", d, {no_move, err}); miscompares++;
        end
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_pref;
        test_win;
        test_block;
        test_no_move;
        test_timeout;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
